fft_reorder8: RTL and testbench

FFT_REORDER8 -- requirements
Module: fft_reorder8

---
 rtl/fft_reorder8.sv | 110 +++++++++++
 tb/tb_fft_reorder8.sv | 462 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_reorder8.sv
// fft_reorder8: reorders 8-point FFT frames from bit-reversed to natural order.
// Ports: clk, reset (async, active-low), in_* valid/ready sample input,
// out_* valid/ready sample output with out_index (bin k) and out_last (k==7).
// Optional macro FFT_REORDER_DROPCNT_EN adds drop_cnt[7:0] (stalled in_valid cycles).
module fft_reorder8 #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_re,
  input  logic [DATA_W-1:0] in_im,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_re,
  output logic [DATA_W-1:0] out_im,
  output logic [2:0]        out_index,
  output logic              out_last
`ifdef FFT_REORDER_DROPCNT_EN
  ,
  output logic [7:0]        drop_cnt
`endif
);

  function automatic logic [2:0] bitrev3(
    input logic [2:0] v
  );
    return {v[0], v[1], v[2]};
  endfunction

  logic [DATA_W-1:0] mem_re [2][8];
  logic [DATA_W-1:0] mem_im [2][8];

  logic [1:0] full;
  logic       wbank;
  logic       rbank;
  logic [2:0] wcnt;
  logic [2:0] rcnt;

  logic       in_fire;
  logic       out_fire;
  logic       wwrap;
  logic       rwrap;
  logic [1:0] set_full;
  logic [1:0] clr_full;

  assign in_ready  = ~full[wbank];
  assign out_valid = full[rbank];
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign wwrap     = in_fire & (wcnt == 3'd7);
  assign rwrap     = out_fire & (rcnt == 3'd7);

  always_comb begin
    set_full = '0;
    clr_full = '0;
    set_full[wbank] = wwrap;
    clr_full[rbank] = rwrap;
  end

  // Set dominates clear; they only meet on one bank if pointers coincide.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      full  <= '0;
      wbank <= 1'b0;
      rbank <= 1'b0;
      wcnt  <= '0;
      rcnt  <= '0;
    end else begin
      full <= set_full | (full & ~clr_full);
      if (in_fire) begin
        wcnt <= wcnt + 3'd1;
      end
      if (wwrap) begin
        wbank <= ~wbank;
      end
      if (out_fire) begin
        rcnt <= rcnt + 3'd1;
      end
      if (rwrap) begin
        rbank <= ~rbank;
      end
    end
  end

  // Sample storage carries no reset; validity lives in the full flags.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      mem_re[wbank][bitrev3(wcnt)] <= in_re;
      mem_im[wbank][bitrev3(wcnt)] <= in_im;
    end
  end

  assign out_re    = mem_re[rbank][rcnt];
  assign out_im    = mem_im[rbank][rcnt];
  assign out_index = rcnt;
  assign out_last  = out_valid & (rcnt == 3'd7);

`ifdef FFT_REORDER_DROPCNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_cnt <= '0;
    end else if (in_valid && !in_ready && drop_cnt != 8'hff) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fft_reorder8.sv
// tb_fft_reorder8: scoreboard bench for fft_reorder8.
// Expected natural-order frames are queued as inputs are accepted.
module tb_fft_reorder8;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_re;
  logic [DW-1:0] in_im;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_re;
  logic [DW-1:0] out_im;
  logic [2:0]    out_index;
  logic          out_last;
`ifdef FFT_REORDER_DROPCNT_EN
  logic [7:0]    drop_cnt;
`endif

  fft_reorder8 #(.DATA_W(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_re     (in_re),
    .in_im     (in_im),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_re    (out_re),
    .out_im    (out_im),
    .out_index (out_index),
    .out_last  (out_last)
`ifdef FFT_REORDER_DROPCNT_EN
    ,
    .drop_cnt  (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] re;
    logic [DW-1:0] im;
    logic [2:0]    idx;
    logic          last;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  int brtab[8] = '{0, 4, 2, 6, 1, 5, 3, 7};
  logic [DW-1:0] fr_re[8];
  logic [DW-1:0] fr_im[8];
  int wpos = 0;

  bit            c_acc;
  bit            c_pop;
  logic          c_vld;
  logic [DW-1:0] c_re;
  logic [DW-1:0] c_im;
  logic [2:0]    c_idx;
  logic          c_last;

  // Advance one cycle: sample at negedge, feed model, return at posedge+1.
  task automatic cycle();
    @(negedge clk);
    c_acc  = in_valid && in_ready;
    c_pop  = out_valid && out_ready;
    c_vld  = out_valid;
    c_re   = out_re;
    c_im   = out_im;
    c_idx  = out_index;
    c_last = out_last;
    if (c_acc) begin
      fr_re[wpos] = in_re;
      fr_im[wpos] = in_im;
      if (wpos == 7) begin
        for (int k = 0; k < 8; k++) begin
          exp_t e;
          e.re   = fr_re[brtab[k]];
          e.im   = fr_im[brtab[k]];
          e.idx  = 3'(k);
          e.last = (k == 7);
          sb.push_back(e);
        end
        wpos = 0;
      end else begin
        wpos++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got %b exp 1", in_ready);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_out_valid got %b exp 0", out_valid);
    end
    checks++;
    if (out_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_out_last got %b exp 0", out_last);
    end
    checks++;
    if (out_index !== 3'd0) begin
      errors++;
      $display("FAIL reset_out_index got %0d exp 0", out_index);
    end
`ifdef FFT_REORDER_DROPCNT_EN
    checks++;
    if (drop_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_drop_cnt got %0d exp 0", drop_cnt);
    end
`endif
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_frame();
    int   seq[8] = '{0, 4, 2, 6, 1, 5, 3, 7};
    int   got = 0;
    exp_t e;
    out_ready = 1'b1;
    for (int n = 0; n < 8; n++) begin
      in_valid = 1'b1;
      in_re = DW'(n);
      in_im = DW'(16'h100 + n);
      cycle();
      checks++;
      if (!c_acc) begin
        errors++;
        $display("FAIL single_accept n=%0d got 0 exp 1", n);
      end
    end
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL single_latency out_valid got %b exp 1", out_valid);
    end
    for (int t = 0; t < 20 && got < 8; t++) begin
      cycle();
      if (c_pop) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL single_extra got re=%h exp none", c_re);
        end else begin
          e = sb.pop_front();
          if ({c_re, c_im, c_idx, c_last} !==
              {e.re, e.im, e.idx, e.last}) begin
            errors++;
            $display("FAIL single_data got %h/%h/%0d/%b exp %h/%h/%0d/%b",
                     c_re, c_im, c_idx, c_last,
                     e.re, e.im, e.idx, e.last);
          end
        end
        checks++;
        if (c_re !== DW'(seq[got]) || c_idx !== 3'(got)) begin
          errors++;
          $display("FAIL single_order got re=%0d idx=%0d exp re=%0d idx=%0d",
                   c_re, c_idx, seq[got], got);
        end
        got++;
      end
    end
    checks++;
    if (got != 8 || sb.size() != 0) begin
      errors++;
      $display("FAIL single_count got %0d left %0d exp 8 left 0",
               got, sb.size());
    end
  endtask

  task automatic test_back_to_back();
    int   sent = 0;
    int   got = 0;
    int   first = -1;
    int   last = -1;
    bit   drop = 0;
    exp_t e;
    out_ready = 1'b1;
    for (int t = 0; t < 100 && got < 24; t++) begin
      in_valid = (sent < 24);
      if (in_valid && !in_ready) begin
        drop = 1;
      end
      if (!c_acc || t == 0) begin
        in_re = DW'($urandom);
        in_im = DW'($urandom);
      end
      cycle();
      if (c_acc) begin
        sent++;
        in_re = DW'($urandom);
        in_im = DW'($urandom);
      end
      if (c_pop) begin
        if (first < 0) first = t;
        last = t;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL b2b_extra got re=%h exp none", c_re);
        end else begin
          e = sb.pop_front();
          if ({c_re, c_im, c_idx, c_last} !==
              {e.re, e.im, e.idx, e.last}) begin
            errors++;
            $display("FAIL b2b_data got %h/%h/%0d/%b exp %h/%h/%0d/%b",
                     c_re, c_im, c_idx, c_last,
                     e.re, e.im, e.idx, e.last);
          end
        end
        got++;
      end
    end
    in_valid = 1'b0;
    checks++;
    if (drop) begin
      errors++;
      $display("FAIL b2b_in_ready got dropped exp always 1");
    end
    checks++;
    if (got != 24 || last - first + 1 != 24) begin
      errors++;
      $display("FAIL b2b_continuous got %0d in %0d cycles exp 24 in 24",
               got, last - first + 1);
    end
    checks++;
    if (first != 8) begin
      errors++;
      $display("FAIL b2b_latency got first=%0d exp 8", first);
    end
  endtask

  task automatic test_stall();
    int   acc = 0;
    int   got = 0;
    exp_t e;
`ifdef FFT_REORDER_DROPCNT_EN
    logic [7:0] base;
    base = drop_cnt;
`endif
    out_ready = 1'b0;
    for (int t = 0; t < 40 && acc < 16; t++) begin
      in_valid = 1'b1;
      in_re = DW'($urandom);
      in_im = DW'($urandom);
      cycle();
      if (c_acc) acc++;
    end
    checks++;
    if (acc != 16 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL stall_full got acc=%0d in_ready=%b exp 16/0",
               acc, in_ready);
    end
    in_re = 16'hdead;
    in_im = 16'hbeef;
    for (int t = 0; t < 3; t++) begin
      cycle();
      checks++;
      if (c_acc) begin
        errors++;
        $display("FAIL stall_17th got accepted exp rejected");
      end
    end
`ifdef FFT_REORDER_DROPCNT_EN
    checks++;
    if (drop_cnt !== base + 8'd3) begin
      errors++;
      $display("FAIL stall_drop_cnt got %0d exp %0d", drop_cnt, base + 8'd3);
    end
`endif
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int t = 0; t < 40 && got < 16; t++) begin
      cycle();
      if (c_pop) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL stall_extra got re=%h exp none", c_re);
        end else begin
          e = sb.pop_front();
          if ({c_re, c_im, c_idx, c_last} !==
              {e.re, e.im, e.idx, e.last}) begin
            errors++;
            $display("FAIL stall_data got %h/%h/%0d/%b exp %h/%h/%0d/%b",
                     c_re, c_im, c_idx, c_last,
                     e.re, e.im, e.idx, e.last);
          end
        end
        got++;
      end
    end
    checks++;
    if (got != 16 || sb.size() != 0) begin
      errors++;
      $display("FAIL stall_count got %0d left %0d exp 16 left 0",
               got, sb.size());
    end
  endtask

  task automatic test_toggle();
    int            sent = 0;
    int            got = 0;
    bit            hold = 0;
    logic [DW-1:0] h_re;
    logic [DW-1:0] h_im;
    logic [2:0]    h_idx;
    exp_t          e;
    out_ready = 1'b0;
    for (int t = 0; t < 200 && got < 16; t++) begin
      out_ready = ~out_ready;
      in_valid = (sent < 16);
      cycle();
      if (c_acc) begin
        sent++;
        in_re = DW'($urandom);
        in_im = DW'($urandom);
      end
      if (hold) begin
        checks++;
        if (c_vld !== 1'b1 || c_re !== h_re ||
            c_im !== h_im || c_idx !== h_idx) begin
          errors++;
          $display("FAIL toggle_hold got %b/%h/%h/%0d exp 1/%h/%h/%0d",
                   c_vld, c_re, c_im, c_idx, h_re, h_im, h_idx);
        end
      end
      hold  = c_vld && !c_pop;
      h_re  = c_re;
      h_im  = c_im;
      h_idx = c_idx;
      if (c_pop) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL toggle_extra got re=%h exp none", c_re);
        end else begin
          e = sb.pop_front();
          if ({c_re, c_im, c_idx, c_last} !==
              {e.re, e.im, e.idx, e.last}) begin
            errors++;
            $display("FAIL toggle_data got %h/%h/%0d/%b exp %h/%h/%0d/%b",
                     c_re, c_im, c_idx, c_last,
                     e.re, e.im, e.idx, e.last);
          end
        end
        got++;
      end
    end
    in_valid = 1'b0;
    checks++;
    if (got != 16 || sb.size() != 0) begin
      errors++;
      $display("FAIL toggle_count got %0d left %0d exp 16 left 0",
               got, sb.size());
    end
  endtask

  task automatic test_mid_reset();
    int   acc = 0;
    int   got = 0;
    exp_t e;
    out_ready = 1'b0;
    for (int t = 0; t < 40 && acc < 13; t++) begin
      in_valid = 1'b1;
      in_re = DW'($urandom);
      in_im = DW'($urandom);
      cycle();
      if (c_acc) acc++;
    end
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre_valid got %b exp 1", out_valid);
    end
    reset = 1'b0;
    sb.delete();
    wpos = 0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_index !== 3'd0) begin
      errors++;
      $display("FAIL mid_reset got v=%b r=%b idx=%0d exp 0/1/0",
               out_valid, in_ready, out_index);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    acc = 0;
    for (int t = 0; t < 40 && got < 8; t++) begin
      in_valid = (acc < 8);
      in_re = DW'($urandom);
      in_im = DW'($urandom);
      cycle();
      if (c_acc) acc++;
      if (c_pop) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL mid_extra got re=%h exp none", c_re);
        end else begin
          e = sb.pop_front();
          if ({c_re, c_im, c_idx, c_last} !==
              {e.re, e.im, e.idx, e.last}) begin
            errors++;
            $display("FAIL mid_data got %h/%h/%0d/%b exp %h/%h/%0d/%b",
                     c_re, c_im, c_idx, c_last,
                     e.re, e.im, e.idx, e.last);
          end
        end
        got++;
      end
    end
    in_valid = 1'b0;
    checks++;
    if (got != 8 || sb.size() != 0) begin
      errors++;
      $display("FAIL mid_count got %0d left %0d exp 8 left 0",
               got, sb.size());
    end
  endtask

  initial begin
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_re     = '0;
    in_im     = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_stall();
    test_toggle();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
